// File: rtl/scalar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scalar_pkg
// Description : Shared constants and lane identifiers for the scalar
//               writeback block (register address width, register count,
//               producer lane ids).
// Revision    : 1.0 - initial release
// ============================================================================
package scalar_pkg;

   // Register address width and the number of architectural registers
   localparam int REG_AW   = 5;
   localparam int NUM_REGS = 32;

   // Producer lanes feeding the writeback port
   typedef enum logic {
      LANE_ALU = 1'b0,
      LANE_MEM = 1'b1
   } lane_e;

   // Returns the lane that should win a contended cycle, given the last winner
   function automatic lane_e rr_next(input lane_e last);
      return (last == LANE_ALU) ? LANE_MEM : LANE_ALU;
   endfunction

endpackage : scalar_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin arbiter. Grants are combinational
//               from the requests; the last-granted lane is remembered so a
//               contended cycle goes to the other lane. After reset lane 0
//               (ALU) wins the first contended cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
   import scalar_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic req0_i,
   input  logic req1_i,
   output logic gnt0_o,
   output logic gnt1_o
);

   lane_e last_q;
   lane_e last_d;
   lane_e prio_w;

   // Grant the lone requester, or the preferred lane when both request
   always_comb begin
      prio_w = rr_next(last_q);
      gnt0_o = req0_i && (!req1_i || (prio_w == LANE_ALU));
      gnt1_o = req1_i && (!req0_i || (prio_w == LANE_MEM));
   end

   // Next value of the last-winner pointer; unchanged on idle cycles
   always_comb begin
      last_d = last_q;
      if (gnt0_o) begin
         last_d = LANE_ALU;
      end else if (gnt1_o) begin
         last_d = LANE_MEM;
      end
   end

   // Pointer register; reset as if MEM won last so ALU takes the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= LANE_MEM;
      end else begin
         last_q <= last_d;
      end
   end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/scalar_writeback.sv
`default_nettype none
// ============================================================================
// Module      : scalar_writeback
// Description : Writeback stage for two producer lanes (ALU, MEM). One lane is
//               granted per cycle (round-robin), its result is registered onto
//               the register-file write port one cycle later, and a pending
//               mask tracks in-flight destinations for RAW hazard queries.
//               Optional macro WB_BYPASS_EN forwards the value being written
//               to matching operand queries and suppresses their hazard.
// Revision    : 1.0 - initial release
// ============================================================================
module scalar_writeback
   import scalar_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NREG  = NUM_REGS
)(
   input  logic              clk,
   input  logic              rst_n,
   // producer lane 0 (ALU)
   input  logic              p0_valid,
   output logic              p0_ready,
   input  logic [REG_AW-1:0] p0_addr,
   input  logic [WIDTH-1:0]  p0_data,
   // producer lane 1 (MEM)
   input  logic              p1_valid,
   output logic              p1_ready,
   input  logic [REG_AW-1:0] p1_addr,
   input  logic [WIDTH-1:0]  p1_data,
   // destination allocation at issue
   input  logic              alloc_valid,
   input  logic [REG_AW-1:0] alloc_addr,
   // register-file write port
   output logic              wb_we,
   output logic [REG_AW-1:0] wb_wr,
   output logic [WIDTH-1:0]  wb_wd,
   // hazard queries
   input  logic [REG_AW-1:0] rr1,
   input  logic [REG_AW-1:0] rr2,
   output logic              hazard1,
   output logic              hazard2,
   // bypassed operands
   output logic              fwd1_valid,
   output logic [WIDTH-1:0]  fwd1_data,
   output logic              fwd2_valid,
   output logic [WIDTH-1:0]  fwd2_data
);

   logic              gnt0_w;
   logic              gnt1_w;
   logic              any_gnt_w;
   logic [REG_AW-1:0] sel_addr_w;
   logic [WIDTH-1:0]  sel_data_w;

   logic              wb_we_q,  wb_we_d;
   logic [REG_AW-1:0] wb_wr_q,  wb_wr_d;
   logic [WIDTH-1:0]  wb_wd_q,  wb_wd_d;
   logic [NREG-1:0]   pending_q, pending_d;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req0_i (p0_valid),
      .req1_i (p1_valid),
      .gnt0_o (gnt0_w),
      .gnt1_o (gnt1_w)
   );

   // Ready is the grant itself; select the winning lane's payload
   always_comb begin
      p0_ready   = gnt0_w;
      p1_ready   = gnt1_w;
      any_gnt_w  = gnt0_w || gnt1_w;
      sel_addr_w = gnt1_w ? p1_addr : p0_addr;
      sel_data_w = gnt1_w ? p1_data : p0_data;
   end

   // Next write-port state: writes to r0 are accepted but never committed;
   // address/data hold their last value while no write is in flight
   always_comb begin
      wb_we_d = any_gnt_w && (sel_addr_w != '0);
      wb_wr_d = wb_wr_q;
      wb_wd_d = wb_wd_q;
      if (wb_we_d) begin
         wb_wr_d = sel_addr_w;
         wb_wd_d = sel_data_w;
      end
   end

   // Next pending mask: clear on commit, then set on alloc so set wins a tie
   always_comb begin
      pending_d = pending_q;
      if (wb_we_q) begin
         pending_d[wb_wr_q] = 1'b0;
      end
      if (alloc_valid && (alloc_addr != '0)) begin
         pending_d[alloc_addr] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   // Write-port and pending-mask registers; reset discards any in-flight result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_we_q   <= 1'b0;
         wb_wr_q   <= '0;
         wb_wd_q   <= '0;
         pending_q <= '0;
      end else begin
         wb_we_q   <= wb_we_d;
         wb_wr_q   <= wb_wr_d;
         wb_wd_q   <= wb_wd_d;
         pending_q <= pending_d;
      end
   end

   assign wb_we = wb_we_q;
   assign wb_wr = wb_wr_q;
   assign wb_wd = wb_wd_q;

`ifdef WB_BYPASS_EN
   // Forward the value being committed this cycle and hide its hazard
   always_comb begin
      fwd1_valid = wb_we_q && (wb_wr_q == rr1) && (rr1 != '0);
      fwd2_valid = wb_we_q && (wb_wr_q == rr2) && (rr2 != '0);
      fwd1_data  = fwd1_valid ? wb_wd_q : '0;
      fwd2_data  = fwd2_valid ? wb_wd_q : '0;
      hazard1    = pending_q[rr1] && !fwd1_valid;
      hazard2    = pending_q[rr2] && !fwd2_valid;
   end
`else
   // No bypass network: hazards come straight from the pending mask
   always_comb begin
      fwd1_valid = 1'b0;
      fwd2_valid = 1'b0;
      fwd1_data  = '0;
      fwd2_data  = '0;
      hazard1    = pending_q[rr1];
      hazard2    = pending_q[rr2];
   end
`endif

endmodule : scalar_writeback
`default_nettype wire

// File: tb/tb_scalar_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_scalar_writeback
// Description : Directed self-checking bench for scalar_writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scalar_writeback;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        p0_valid, p1_valid;
   logic        p0_ready, p1_ready;
   logic [4:0]  p0_addr, p1_addr;
   logic [31:0] p0_data, p1_data;
   logic        alloc_valid;
   logic [4:0]  alloc_addr;
   logic        wb_we;
   logic [4:0]  wb_wr;
   logic [31:0] wb_wd;
   logic [4:0]  rr1, rr2;
   logic        hazard1, hazard2;
   logic        fwd1_valid, fwd2_valid;
   logic [31:0] fwd1_data, fwd2_data;

   int checks   = 0;
   int failures = 0;

   scalar_writeback #(.WIDTH(32), .NREG(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .p0_valid    (p0_valid),
      .p0_ready    (p0_ready),
      .p0_addr     (p0_addr),
      .p0_data     (p0_data),
      .p1_valid    (p1_valid),
      .p1_ready    (p1_ready),
      .p1_addr     (p1_addr),
      .p1_data     (p1_data),
      .alloc_valid (alloc_valid),
      .alloc_addr  (alloc_addr),
      .wb_we       (wb_we),
      .wb_wr       (wb_wr),
      .wb_wd       (wb_wd),
      .rr1         (rr1),
      .rr2         (rr2),
      .hazard1     (hazard1),
      .hazard2     (hazard2),
      .fwd1_valid  (fwd1_valid),
      .fwd1_data   (fwd1_data),
      .fwd2_valid  (fwd2_valid),
      .fwd2_data   (fwd2_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      p0_valid = 0; p1_valid = 0; p0_addr = 0; p1_addr = 0;
      p0_data = 0; p1_data = 0; alloc_valid = 0; alloc_addr = 0;
      rr1 = 0; rr2 = 0;
      #12;
      // reset state
      chk("rst_we", {31'd0, wb_we}, 32'd0);
      chk("rst_wr", {27'd0, wb_wr}, 32'd0);
      chk("rst_wd", wb_wd, 32'd0);
      chk("rst_fwd1", {31'd0, fwd1_valid}, 32'd0);
      rst_n = 1'b1;
      step();

      // contention from reset: p0, p1, p0, p1
      p0_valid = 1; p0_addr = 5'd1; p0_data = 32'h11;
      p1_valid = 1; p1_addr = 5'd2; p1_data = 32'h22;
      #1;
      chk("rr0_p0rdy", {31'd0, p0_ready}, 32'd1);
      chk("rr0_p1rdy", {31'd0, p1_ready}, 32'd0);
      step();
      chk("rr1_p0rdy", {31'd0, p0_ready}, 32'd0);
      chk("rr1_p1rdy", {31'd0, p1_ready}, 32'd1);
      chk("rr1_wr", {27'd0, wb_wr}, 32'd1);
      chk("rr1_wd", wb_wd, 32'h11);
      step();
      chk("rr2_p0rdy", {31'd0, p0_ready}, 32'd1);
      chk("rr2_wr", {27'd0, wb_wr}, 32'd2);
      chk("rr2_wd", wb_wd, 32'h22);
      step();
      chk("rr3_p1rdy", {31'd0, p1_ready}, 32'd1);
      chk("rr3_wr", {27'd0, wb_wr}, 32'd1);
      step();
      p0_valid = 0; p1_valid = 0;
      chk("rr4_we", {31'd0, wb_we}, 32'd1);
      chk("rr4_wr", {27'd0, wb_wr}, 32'd2);
      step();
      chk("rr5_we", {31'd0, wb_we}, 32'd0);

      // alloc r5, p0 writes r5 = 0x1234
      alloc_valid = 1; alloc_addr = 5'd5; rr1 = 5'd5;
      step();
      alloc_valid = 0;
      #1;
      chk("a5_haz", {31'd0, hazard1}, 32'd1);
      p0_valid = 1; p0_addr = 5'd5; p0_data = 32'h1234;
      #1;
      chk("a5_p0rdy", {31'd0, p0_ready}, 32'd1);
      step();
      p0_valid = 0;
      #1;
      chk("a5_we", {31'd0, wb_we}, 32'd1);
      chk("a5_wr", {27'd0, wb_wr}, 32'd5);
      chk("a5_wd", wb_wd, 32'h1234);
      chk("a5_haz_wb", {31'd0, hazard1}, BYP ? 32'd0 : 32'd1);
      chk("a5_fwd1v", {31'd0, fwd1_valid}, BYP ? 32'd1 : 32'd0);
      step();
      chk("a5_haz_clr", {31'd0, hazard1}, 32'd0);
      chk("a5_we_off", {31'd0, wb_we}, 32'd0);
      chk("a5_wr_hold", {27'd0, wb_wr}, 32'd5);

      // p1 writes r0: accepted, never committed, pending untouched
      alloc_valid = 1; alloc_addr = 5'd9; rr2 = 5'd9; rr1 = 5'd0;
      step();
      alloc_valid = 0;
      p1_valid = 1; p1_addr = 5'd0; p1_data = 32'hFFFF;
      #1;
      chk("r0_p1rdy", {31'd0, p1_ready}, 32'd1);
      step();
      p1_valid = 0;
      #1;
      chk("r0_we", {31'd0, wb_we}, 32'd0);
      chk("r0_wd_hold", wb_wd, 32'h1234);
      chk("r0_haz9", {31'd0, hazard2}, 32'd1);
      chk("r0_haz_rr0", {31'd0, hazard1}, 32'd0);
      step();
      chk("r0_we2", {31'd0, wb_we}, 32'd0);

      // alloc r7 on the same edge that commits r7
      alloc_valid = 1; alloc_addr = 5'd7; rr1 = 5'd7;
      step();
      alloc_valid = 0;
      p0_valid = 1; p0_addr = 5'd7; p0_data = 32'h77;
      step();
      p0_valid = 0;
      alloc_valid = 1; alloc_addr = 5'd7;
      #1;
      chk("r7_we", {31'd0, wb_we}, 32'd1);
      chk("r7_wr", {27'd0, wb_wr}, 32'd7);
      chk("r7_haz_wb", {31'd0, hazard1}, BYP ? 32'd0 : 32'd1);
      step();
      alloc_valid = 0;
      #1;
      chk("r7_haz_keep", {31'd0, hazard1}, 32'd1);
      step();
      chk("r7_haz_keep2", {31'd0, hazard1}, 32'd1);

      // write r3 = 0xA5 with rr2 = 3
      alloc_valid = 1; alloc_addr = 5'd3; rr2 = 5'd3;
      step();
      alloc_valid = 0;
      p0_valid = 1; p0_addr = 5'd3; p0_data = 32'hA5;
      step();
      p0_valid = 0;
      #1;
      chk("r3_fwd2v", {31'd0, fwd2_valid}, BYP ? 32'd1 : 32'd0);
      chk("r3_fwd2d", fwd2_data, BYP ? 32'hA5 : 32'd0);
      chk("r3_haz2", {31'd0, hazard2}, BYP ? 32'd0 : 32'd1);
      chk("r3_fwd1v", {31'd0, fwd1_valid}, 32'd0);
      step();
      chk("r3_haz2_clr", {31'd0, hazard2}, 32'd0);
      chk("r3_fwd2v_off", {31'd0, fwd2_valid}, 32'd0);

      // reset pulse right after a grant discards the result
      rr2 = 5'd9;
      alloc_valid = 1; alloc_addr = 5'd12; rr1 = 5'd12;
      step();
      alloc_valid = 0;
      p0_valid = 1; p0_addr = 5'd12; p0_data = 32'hC;
      #1;
      chk("rst_p0rdy", {31'd0, p0_ready}, 32'd1);
      chk("rst_pre_haz9", {31'd0, hazard2}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_haz9", {31'd0, hazard2}, 32'd0);
      step();
      p0_valid = 0;
      rst_n = 1'b1;
      #1;
      chk("rst_we0", {31'd0, wb_we}, 32'd0);
      chk("rst_haz12", {31'd0, hazard1}, 32'd0);
      step();
      chk("rst_we1", {31'd0, wb_we}, 32'd0);
      chk("rst_haz9_post", {31'd0, hazard2}, 32'd0);
      // pointer back to reset value: ALU wins a tie again
      p0_valid = 1; p1_valid = 1; p0_addr = 5'd4; p1_addr = 5'd6;
      #1;
      chk("rst_rr_p0", {31'd0, p0_ready}, 32'd1);
      chk("rst_rr_p1", {31'd0, p1_ready}, 32'd0);
      p0_valid = 0; p1_valid = 0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_scalar_writeback
`default_nettype wire
